// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - requester and CDB signal bundle for the CDB arbiter
interface cdb_arbiter_if #(
   parameter int NUM_REQ   = 6,
   parameter int CDB_WIDTH = 3,
   parameter int TAG_W     = 5,
   parameter int XLEN      = 32
) ();
   logic [NUM_REQ-1:0]                  req_valid;
   logic [NUM_REQ-1:0][TAG_W-1:0]       req_rob_tag;
   logic [NUM_REQ-1:0][XLEN-1:0]        req_value;
   logic [NUM_REQ-1:0]                  req_ready;
   logic                                complete_en;
   logic [CDB_WIDTH-1:0]                cdb_valid;
   logic [CDB_WIDTH-1:0][TAG_W-1:0]     CDB_rob_num;
   logic [CDB_WIDTH-1:0][XLEN-1:0]      CDB_value;

   // Requester/ROB side: drives completions, observes grants and the CDB.
   modport master (
      output req_valid, req_rob_tag, req_value,
      input  req_ready, complete_en, cdb_valid, CDB_rob_num, CDB_value
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_rob_tag, req_value,
      output req_ready, complete_en, cdb_valid, CDB_rob_num, CDB_value
   );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin multi-slot CDB arbiter with registered broadcast
module cdb_arbiter #(
   parameter int NUM_REQ   = 6,
   parameter int CDB_WIDTH = 3,
   parameter int ROB_SIZE  = 32,
   parameter int XLEN      = 32,
   localparam int TAG_W    = $clog2(ROB_SIZE),
   localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   cdb_arbiter_if.slave     bus,
   output logic [PTR_W-1:0] rr_ptr_test
);
   localparam int CNT_W = $clog2(CDB_WIDTH + 1);
   localparam int SUM_W = PTR_W + 1;

   logic [PTR_W-1:0]                rr_ptr;
   logic [PTR_W-1:0]                rr_next;
   logic [PTR_W-1:0]                idx;
   logic [PTR_W-1:0]                last_idx;
   logic [SUM_W-1:0]                sum;
   logic [SUM_W-1:0]                inc;
   logic [CNT_W-1:0]                cnt;
   logic [NUM_REQ-1:0]              grant;
   logic [CDB_WIDTH-1:0]            nxt_valid;
   logic [CDB_WIDTH-1:0][TAG_W-1:0] nxt_tag;
   logic [CDB_WIDTH-1:0][XLEN-1:0]  nxt_value;
   logic [CDB_WIDTH-1:0]            cdb_valid_q;
   logic [CDB_WIDTH-1:0][TAG_W-1:0] cdb_tag_q;
   logic [CDB_WIDTH-1:0][XLEN-1:0]  cdb_value_q;

   // Scan from rr_ptr with wraparound, granting the first CDB_WIDTH valid requesters
   // and packing them into slots 0.. in scan order. Nothing is granted in reset or flush.
   always_comb begin
      grant     = '0;
      nxt_valid = '0;
      nxt_tag   = '0;
      nxt_value = '0;
      cnt       = '0;
      sum       = '0;
      idx       = '0;
      last_idx  = rr_ptr;
      for (int j = 0; j < NUM_REQ; j++) begin
         sum = {1'b0, rr_ptr} + SUM_W'(j);
         if (sum >= SUM_W'(NUM_REQ)) begin
            sum = sum - SUM_W'(NUM_REQ);
         end
         idx = sum[PTR_W-1:0];
         if (reset && !flush && bus.req_valid[idx] && (cnt < CNT_W'(CDB_WIDTH))) begin
            grant[idx]     = 1'b1;
            nxt_valid[cnt] = 1'b1;
            nxt_tag[cnt]   = bus.req_rob_tag[idx];
            nxt_value[cnt] = bus.req_value[idx];
            last_idx       = idx;
            cnt            = cnt + CNT_W'(1);
         end
      end
   end

   // Next start index is one past the last winner; unchanged when nobody won.
   always_comb begin
      inc     = {1'b0, last_idx} + SUM_W'(1);
      rr_next = rr_ptr;
      if (cnt != '0) begin
         rr_next = (inc >= SUM_W'(NUM_REQ)) ? '0 : inc[PTR_W-1:0];
      end
   end

   // CDB slot register and round-robin pointer; flush wipes both at the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr      <= '0;
         cdb_valid_q <= '0;
         cdb_tag_q   <= '0;
         cdb_value_q <= '0;
      end else if (flush) begin
         rr_ptr      <= '0;
         cdb_valid_q <= '0;
         cdb_tag_q   <= '0;
         cdb_value_q <= '0;
      end else begin
         rr_ptr      <= rr_next;
         cdb_valid_q <= nxt_valid;
         cdb_tag_q   <= nxt_tag;
         cdb_value_q <= nxt_value;
      end
   end

   assign bus.req_ready   = grant;
   assign bus.cdb_valid   = cdb_valid_q;
   assign bus.CDB_rob_num = cdb_tag_q;
   assign bus.CDB_value   = cdb_value_q;
   assign bus.complete_en = |cdb_valid_q;
   assign rr_ptr_test     = rr_ptr;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard testbench for cdb_arbiter
module tb_cdb_arbiter;
   localparam int NUM_REQ   = 6;
   localparam int CDB_WIDTH = 3;
   localparam int ROB_SIZE  = 32;
   localparam int XLEN      = 32;
   localparam int TAG_W     = 5;
   localparam int NV        = 11;

   localparam logic [5:0] V_VALID [NV] = '{6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h08, 6'h33, 6'h04, 6'h3F, 6'h00, 6'h3F, 6'h01};
   localparam logic       V_FLUSH [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam logic [5:0] V_READY [NV] = '{6'h07, 6'h38, 6'h07, 6'h38, 6'h08, 6'h31, 6'h04, 6'h00, 6'h00, 6'h07, 6'h01};
   localparam logic [2:0] V_CV    [NV] = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd1, 3'd7, 3'd1, 3'd0, 3'd0, 3'd7, 3'd1};
   localparam int         V_SRC   [NV][3] = '{'{0,1,2}, '{3,4,5}, '{0,1,2}, '{3,4,5}, '{3,0,0}, '{4,5,0},
                                             '{2,0,0}, '{0,0,0}, '{0,0,0}, '{0,1,2}, '{0,0,0}};
   localparam logic [2:0] V_RR    [NV] = '{3'd3, 3'd0, 3'd3, 3'd0, 3'd4, 3'd1, 3'd3, 3'd0, 3'd0, 3'd3, 3'd1};
   localparam logic [4:0]  TAG_OF [6] = '{5'd4, 5'd9, 5'd5, 5'd20, 5'd31, 5'd12};
   localparam logic [31:0] VAL_OF [6] = '{32'd100, 32'd200, 32'd17, 32'd400, 32'd500, 32'd600};

   typedef struct packed {
      logic [2:0]       cv;
      logic [2:0][4:0]  tag;
      logic [2:0][31:0] val;
      logic [2:0]       rr;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       flush = 1'b0;
   logic [2:0] rr_ptr_test;
   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   int         gcount [NUM_REQ];

   cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .CDB_WIDTH(CDB_WIDTH), .TAG_W(TAG_W), .XLEN(XLEN)) bus ();

   cdb_arbiter #(.NUM_REQ(NUM_REQ), .CDB_WIDTH(CDB_WIDTH), .ROB_SIZE(ROB_SIZE), .XLEN(XLEN)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .bus         (bus),
      .rr_ptr_test (rr_ptr_test)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic apply(input int i);
      exp_t       e;
      logic [2:0] cv;
      logic [5:0] rdy;
      int         src;
      @(negedge clk);
      bus.req_valid = V_VALID[i];
      flush         = V_FLUSH[i];
      #1;
      rdy = V_READY[i];
      check($sformatf("ready v%0d", i), bus.req_ready, rdy);
      for (int r = 0; r < NUM_REQ; r++) begin
         if (bus.req_ready[r]) gcount[r]++;
      end
      cv = V_CV[i];
      e  = '0;
      e.cv = cv;
      e.rr = V_RR[i];
      for (int k = 0; k < CDB_WIDTH; k++) begin
         src = V_SRC[i][k];
         if (cv[k]) begin
            e.tag[k] = TAG_OF[src];
            e.val[k] = VAL_OF[src];
         end
      end
      @(posedge clk);
      sb.push_back(e);
   endtask

   // Monitor: compares each broadcast cycle against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("cdb_valid", bus.cdb_valid, e.cv);
            check("complete_en", bus.complete_en, |e.cv);
            check("CDB_rob_num", bus.CDB_rob_num, e.tag);
            check("CDB_value", bus.CDB_value, e.val);
            check("rr_ptr", rr_ptr_test, e.rr);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      for (int r = 0; r < NUM_REQ; r++) begin
         bus.req_rob_tag[r] = TAG_OF[r];
         bus.req_value[r]   = VAL_OF[r];
         gcount[r]          = 0;
      end
      bus.req_valid = 6'h3F;
      #1 reset = 1'b0;
      #1;
      check("reset cdb_valid", bus.cdb_valid, 3'b000);
      check("reset complete_en", bus.complete_en, 1'b0);
      check("reset rr_ptr", rr_ptr_test, 3'd0);
      check("reset ready", bus.req_ready, 6'h00);
      bus.req_valid = 6'h00;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         apply(i);
         if (i == 3) begin
            for (int r = 0; r < NUM_REQ; r++) begin
               check($sformatf("grant count req%0d", r), gcount[r], 2);
            end
         end
      end
      @(negedge clk);
      bus.req_valid = 6'h3F;
      flush = 1'b0;
      #3 reset = 1'b0;
      #1;
      check("async cdb_valid", bus.cdb_valid, 3'b000);
      check("async complete_en", bus.complete_en, 1'b0);
      check("async CDB_rob_num", bus.CDB_rob_num, 15'd0);
      check("async CDB_value", bus.CDB_value, 96'd0);
      check("async rr_ptr", rr_ptr_test, 3'd0);
      check("async ready", bus.req_ready, 6'h00);
      bus.req_valid = 6'h00;
      @(negedge clk);
      reset = 1'b1;
      apply(10);
      @(negedge clk);
      bus.req_valid = 6'h00;
      @(negedge clk);
      @(negedge clk);
      check("scoreboard drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
